// File: rtl/rchdc_pkg.sv
// Shared types and helpers for the skid register slice.
package rchdc_pkg;

    localparam int unsigned LEVEL_W = 2;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } slice_state_t;

    // Number of beats held by the slice in a given state.
    function automatic logic [LEVEL_W-1:0] state_level(input slice_state_t s);
        case (s)
            S_BUSY:  return 2'd1;
            S_FULL:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/skid_slice_dff_en.sv
// Load-enabled register with synchronous active-high clear.
module dff_en #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear on reset, otherwise capture d when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/skid_slice.sv
// Full-throughput valid/ready register slice with a two-entry skid buffer.
// The main register drives m_data; the skid register catches the beat that
// arrives in the cycle the downstream stalls, so s_ready can be a decode of
// registered state instead of a combinational function of m_ready.
module skid_slice
    import rchdc_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DW-1:0]        m_data,
    output logic [LEVEL_W-1:0]   level
);

    slice_state_t  state;
    slice_state_t  state_next;
    logic          in_xfer;
    logic          out_xfer;
    logic          main_load;
    logic          skid_load;
    logic [DW-1:0] main_d;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;

    // Interface decodes: all depend only on registered state (and rst).
    assign s_ready  = (state != S_FULL) && !rst;
    assign m_valid  = (state != S_EMPTY);
    assign m_data   = main_q;
    assign level    = state_level(state);
    assign in_xfer  = s_valid && s_ready;
    assign out_xfer = m_valid && m_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode from the two handshakes.
    always_comb begin
        state_next = state;
        case (state)
            S_EMPTY: begin
                if (in_xfer) state_next = S_BUSY;
            end
            S_BUSY: begin
                if (in_xfer && !out_xfer)      state_next = S_FULL;
                else if (!in_xfer && out_xfer) state_next = S_EMPTY;
            end
            S_FULL: begin
                if (out_xfer) state_next = S_BUSY;
            end
            default: state_next = S_EMPTY;
        endcase
    end

    // Data-path controls: which register loads and from where.
    always_comb begin
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = s_data;
        case (state)
            S_EMPTY: begin
                main_load = in_xfer;
            end
            S_BUSY: begin
                main_load = in_xfer && out_xfer;
                skid_load = in_xfer && !out_xfer;
            end
            S_FULL: begin
                main_load = out_xfer;
                main_d    = skid_q;
            end
            default: begin
                main_load = 1'b0;
            end
        endcase
    end

    dff_en #(.W(DW)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_load),
        .d   (main_d),
        .q   (main_q)
    );

    dff_en #(.W(DW)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_load),
        .d   (s_data),
        .q   (skid_q)
    );

endmodule

// File: tb/tb_skid_slice.sv
// Self-checking bench for skid_slice against a queue-based behavioural model.
module tb_skid_slice;

    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [1:0]    level;

    int checks   = 0;
    int failures = 0;
    int cycles   = 0;

    // Model: beats currently held, oldest first; capacity two.
    logic [DW-1:0] mq[$];
    // Beats observed leaving the DUT at downstream handshakes.
    logic [DW-1:0] dut_emit_q[$];

    skid_slice #(.DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .level   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; the model decides transfers from its own occupancy.
    task automatic tick();
        bit            will_in;
        bit            will_out;
        logic [DW-1:0] din;
        will_in  = !rst && s_valid && (mq.size() < 2);
        will_out = !rst && (mq.size() > 0) && m_ready;
        din      = s_data;
        if (!rst && m_valid && m_ready) dut_emit_q.push_back(m_data);
        @(posedge clk);
        #1;
        cycles++;
        if (rst) begin
            mq.delete();
        end else begin
            if (will_out) void'(mq.pop_front());
            if (will_in)  mq.push_back(din);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        m_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || level !== 2'd0) begin
                failures++;
                $display("FAIL reset_hold cyc%0d: s_ready=%b m_valid=%b m_data=%h level=%0d, required 0/0/0/0",
                         i, s_ready, m_valid, m_data, level);
            end
        end
        rst     = 1'b0;
        s_valid = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: s_ready=%b required 1", s_ready);
        end
        tick();
        checks++;
        if (m_valid !== 1'b0 || level !== 2'd0) begin
            failures++;
            $display("FAIL reset_no_beat: m_valid=%b level=%0d required 0/0", m_valid, level);
        end
    endtask

    task automatic test_pass_through();
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(i);
            checks++;
            if (s_ready !== 1'b1) begin
                failures++;
                $display("FAIL pass_ready beat%0d: s_ready=%b required 1", i, s_ready);
            end
            tick();
            checks++;
            if (m_valid !== 1'b1 || m_data !== DW'(i) || level !== 2'd1) begin
                failures++;
                $display("FAIL pass_beat%0d: m_valid=%b m_data=%h level=%0d required 1/%h/1",
                         i, m_valid, m_data, level, DW'(i));
            end
        end
        s_valid = 1'b0;
        tick();
        checks++;
        if (m_valid !== 1'b0 || level !== 2'd0 || mq.size() != 0) begin
            failures++;
            $display("FAIL pass_drain: m_valid=%b level=%0d required 0/0", m_valid, level);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] vals[3];
        vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
        dut_emit_q.delete();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = vals[i];
            checks++;
            if (s_ready !== (mq.size() < 2)) begin
                failures++;
                $display("FAIL bp_ready beat%0d: s_ready=%b required %b", i, s_ready, mq.size() < 2);
            end
            tick();
            checks++;
            if (m_valid !== 1'b1 || m_data !== 32'hA || level !== 2'(mq.size())) begin
                failures++;
                $display("FAIL bp_hold beat%0d: m_valid=%b m_data=%h level=%0d required 1/a/%0d",
                         i, m_valid, m_data, level, mq.size());
            end
        end
        checks++;
        if (level !== 2'd2 || s_ready !== 1'b0 || mq.size() != 2) begin
            failures++;
            $display("FAIL bp_full: level=%0d s_ready=%b required 2/0", level, s_ready);
        end
    endtask

    task automatic test_drain();
        // s_valid/s_data still offer 0xC from the fill phase.
        m_ready = 1'b1;
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'hB || level !== 2'd1 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL drain_first: m_valid=%b m_data=%h level=%0d s_ready=%b required 1/b/1/1",
                     m_valid, m_data, level, s_ready);
        end
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'hC || level !== 2'd1) begin
            failures++;
            $display("FAIL drain_accept_c: m_valid=%b m_data=%h level=%0d required 1/c/1",
                     m_valid, m_data, level);
        end
        s_valid = 1'b0;
        tick();
        checks++;
        if (level !== 2'd0 || m_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: level=%0d m_valid=%b required 0/0", level, m_valid);
        end
        checks++;
        if (dut_emit_q.size() != 3) begin
            failures++;
            $display("FAIL drain_count: emitted=%0d required 3", dut_emit_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_emit_q[i] !== DW'(32'hA + i)) begin
                    failures++;
                    $display("FAIL drain_order idx%0d: got %h required %h", i, dut_emit_q[i], DW'(32'hA + i));
                end
            end
        end
    endtask

    task automatic test_random();
        localparam int NBEATS = 10000;
        localparam int BUDGET = 60000;
        int            next_val;
        int            n;
        bit            prev_stall;
        logic [DW-1:0] prev_data;
        dut_emit_q.delete();
        next_val   = 0;
        n          = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (dut_emit_q.size() < NBEATS && n < BUDGET) begin
            s_valid = (next_val < NBEATS) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_data  = DW'(next_val);
            m_ready = 1'($urandom_range(0, 1));
            if (s_valid && mq.size() < 2) next_val++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            tick();
            n++;
            checks++;
            if (level !== 2'(mq.size()) || level > 2'd2 || m_valid !== (mq.size() > 0)
                || (mq.size() > 0 && m_data !== mq[0])) begin
                failures++;
                $display("FAIL rand_state cyc%0d: level=%0d m_valid=%b m_data=%h required level=%0d head=%h",
                         n, level, m_valid, m_data, mq.size(), (mq.size() > 0) ? mq[0] : '0);
            end
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== prev_data) begin
                    failures++;
                    $display("FAIL rand_stall_stable cyc%0d: m_valid=%b m_data=%h required 1/%h",
                             n, m_valid, m_data, prev_data);
                end
            end
        end
        checks++;
        if (dut_emit_q.size() != NBEATS) begin
            failures++;
            $display("FAIL rand_budget: emitted=%0d required %0d", dut_emit_q.size(), NBEATS);
        end
        for (int i = 0; i < dut_emit_q.size(); i++) begin
            checks++;
            if (dut_emit_q[i] !== DW'(i)) begin
                failures++;
                $display("FAIL rand_order idx%0d: got %h required %h", i, dut_emit_q[i], DW'(i));
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h5;
        tick();
        s_data  = 32'h6;
        tick();
        checks++;
        if (level !== 2'd2 || m_data !== 32'h5) begin
            failures++;
            $display("FAIL rmid_fill: level=%0d m_data=%h required 2/5", level, m_data);
        end
        dut_emit_q.delete();
        s_valid = 1'b0;
        rst     = 1'b1;
        tick();
        rst     = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || level !== 2'd0) begin
            failures++;
            $display("FAIL rmid_cleared: m_valid=%b level=%0d required 0/0", m_valid, level);
        end
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h7;
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h7 || level !== 2'd1) begin
            failures++;
            $display("FAIL rmid_new_beat: m_valid=%b m_data=%h level=%0d required 1/7/1",
                     m_valid, m_data, level);
        end
        s_valid = 1'b0;
        tick();
        checks++;
        if (dut_emit_q.size() != 1 || dut_emit_q[0] !== 32'h7) begin
            failures++;
            $display("FAIL rmid_emitted: count=%0d first=%h required 1/7",
                     dut_emit_q.size(), (dut_emit_q.size() > 0) ? dut_emit_q[0] : '0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        test_reset();
        test_pass_through();
        test_backpressure();
        test_drain();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/skid_slice.md
Name: skid_slice

Overview:
- Full-throughput valid/ready register slice with a two-entry skid buffer.
- Cuts the combinational path in both directions of a streaming interface: forward data/valid and backward ready.
- Sits between pipeline stages wherever a plain DFF stage must also carry backpressure.
- Every output comes from a register, except s_ready, which is a decode of registered state and rst only.

Parameters:
- DW, 32, payload width in bits (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- s_valid  input  1  upstream beat valid
- s_ready  output  1  slice can accept a beat this cycle
- s_data  input  DW  upstream payload
- m_valid  output  1  downstream beat valid
- m_ready  input  1  downstream accepts beat
- m_data  output  DW  downstream payload
- level  output  2  beats held: 0, 1 or 2

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Transfer rules: upstream transfer when s_valid && s_ready at a rising clk edge; downstream transfer when m_valid && m_ready at a rising clk edge.
- Storage: main register (drives m_data) and skid register.
- State register: EMPTY (level 0), BUSY (main full, level 1), FULL (main and skid full, level 2).
- Outputs:
  - m_valid = (state != EMPTY), registered.
  - s_ready = (state != FULL) && !rst; no combinational path from m_ready or s_valid.
- Reset (rst high at an edge): state <= EMPTY, main and skid <= 0. Outputs: m_valid=0, m_data=0, level=0, s_ready=0 while rst is high. s_valid is ignored while rst is high.
- Reset mid-operation discards all held beats without any downstream transfer.
- Transitions ("in" = upstream transfer, "out" = downstream transfer):
  - EMPTY: in -> main<=s_data, BUSY; else stay.
  - BUSY, in && out -> main<=s_data, stay BUSY (pass-through, 1 beat/cycle).
  - BUSY, in && !out -> skid<=s_data, FULL.
  - BUSY, !in && out -> EMPTY.
  - BUSY, neither -> hold.
  - FULL (s_ready=0, so no "in" is possible): out -> main<=skid, BUSY; else hold.
- Latency: a beat accepted at edge N appears on m_valid/m_data after edge N, i.e. one cycle. Sustained throughput is 1 beat/cycle with m_ready held high.
- Ordering: strict FIFO; no beat is dropped or duplicated.
- Stability: while m_valid && !m_ready, m_valid and m_data do not change.
- Data registers load only on the listed transitions. Skid contents are don't-care except in FULL (reset to 0 regardless).
- Upstream protocol violations (s_data changing while s_valid && !s_ready) are not checked. Only the value present at a transfer edge is captured.
- No width arithmetic. level is a direct decode of state.

Decomposition:
- Shared package rchdc_pkg holds:
  - typedef enum logic [1:0] slice_state_t {S_EMPTY=0, S_BUSY=1, S_FULL=2}
  - a function mapping slice_state_t to level.
- One natural sub-module: dff_en (DW-parameterized register with load enable and synchronous active-high reset to 0). It is instantiated twice, for main and skid.
- State/control logic stays in skid_slice.

Test Plan:
- Reset: hold rst=1 for 3 cycles with s_valid=1, s_data=0xDEAD_BEEF -> s_ready=0, m_valid=0, m_data=0, level=0 throughout. After release, s_ready=1 and no beat is emitted.
- Pass-through: m_ready=1, drive 0x1,0x2,...,0x10 on consecutive cycles -> m_data shows 0x1..0x10 on consecutive cycles, each 1 cycle after acceptance; level stays 1; s_ready stays 1.
- Backpressure fill: m_ready=0, send 0xA, 0xB, 0xC back-to-back -> 0xA and 0xB accepted, level=2, s_ready=0 on the 0xC cycle, 0xC not accepted. m_data holds 0xA stable.
- Drain: from that FULL state, raise m_ready for 1 cycle -> 0xA transfers, m_data=0xB, level=1, s_ready=1. Then 0xC is accepted, and the output order is 0xA, 0xB, 0xC.
- Random stress: random s_valid/m_ready (50% each), 10,000 beats of incrementing data -> scoreboard sees identical in-order sequence. Assertions hold: m_data stable under stall, level==popcount of held beats, never level>2.
- Reset mid-operation: in FULL with 0x5, 0x6 held, pulse rst for 1 cycle -> next cycle m_valid=0, level=0. Neither 0x5 nor 0x6 is ever emitted, and a new beat 0x7 then passes with 1-cycle latency.
